axis_to_rs232: RTL and testbench
================================

Name: axis_to_rs232

Overview:
- Transmit counterpart of the RS232 receive path: converts an 8-bit AXI-stream byte interface into an RS232 serial frame on TXD with hardware flow control.
- Each frame is 8N1, or 8N2 when STOP_BITS is 2.
- The CTSn input is driven by the RTSn output of the remote receiver; new frames start only while it is low.
- Sits between the on-chip byte source (FIFO or packet logic) and the FT2232-style USB-serial bridge pins.

Parameters:
- CLOCK_FREQ, 133000000 (real): clock frequency in Hz.
- BAUD_RATE, 115200 (real): bit rate in Hz.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- idata  input  8  byte to transmit; sent LSB first.
- ivalid  input  1  AXI-stream valid.
- iready  output  1  AXI-stream ready.
- txd_pin  output  1  serial data; connects to the RXD pin of the remote receiver; idles high.
- ctsn_pin  input  1  clear-to-send, active-low; connects to the RTSn pin of the remote receiver.

Behaviour:
- Bit period: N = BAUD_COUNT_FULL = CLOCK_FREQ/BAUD_RATE, rounded to nearest.
  - N >= 2 is required; elaboration fails otherwise.
  - The baud counter width is derived from N via $clog2. It counts down and reloads on each bit boundary, so every bit lasts exactly N clocks with no cumulative drift.
- CTSn synchronizer: two flops, both reset to 1 (blocked). cts_ok = synchronized ctsn == 0.
- States: IDLE, START, DATA (bit index 0..7), STOP (1 or STOP_BITS bit periods).
  - A 4-bit state counter with encoded values is acceptable.
- iready = (state == IDLE) && cts_ok. It depends only on registers, never on ivalid.
- Transfer occurs on a clock edge with ivalid && iready.
  - idata is latched into the shift register.
  - The state goes to START and the baud counter loads N.
- txd_pin is registered. It is 0 throughout START, equals shift[0] throughout DATA, and is 1 in STOP and IDLE.
  - The start bit appears on txd_pin the cycle after the transfer edge.
- At each bit boundary (baud tick): START->DATA bit 0; DATA shifts right and increments the index; after bit 7 -> STOP; after the last stop period -> IDLE.
- Frame length: exactly (9+STOP_BITS)*N clocks from the first start-bit cycle to the first cycle of IDLE.
  - Back-to-back: with ivalid held high and CTSn low, the next start bit begins exactly (9+STOP_BITS)*N+1 clocks after the previous one (one IDLE cycle for the handshake).
- Flow control is sampled only in IDLE.
  - CTSn rising mid-frame does not abort or stretch the current frame; the frame completes and iready stays 0 afterwards.
  - CTSn pulses shorter than 2 clocks may be missed; this is acceptable.
- idata/ivalid changes while not in IDLE are ignored. No byte is lost or duplicated.
  - A byte is consumed only by a completed handshake.
- Reset values: txd_pin=1, iready=0, state=IDLE, both sync flops=1. The shift register needs no reset.
- Reset asserted mid-frame: txd_pin goes to 1 immediately (asynchronous) and the partial frame is abandoned.
  - After release, iready rises no earlier than 2 clocks later, once synchronized CTSn reads low.

Test Plan:
- CLOCK_FREQ=1e6, BAUD_RATE=1e5 (N=10), CTSn low, send 0x55.
  - txd_pin = 0,1,0,1,0,1,0,1,0,1 then 1, each level held exactly 10 clocks.
  - iready low for 100 clocks after the transfer edge, then 1.
- Same settings, bytes 0xA5 and 0x3C with ivalid held high.
  - Second start-bit falling edge exactly 101 clocks after the first.
  - Decoded bytes 0xA5, 0x3C.
- CTSn held high, ivalid=1, idata=0xFF for 200 clocks: iready=0 and txd_pin=1 throughout.
  - Drive CTSn low: iready=1 within 3 clocks, and a frame of 0xFF follows.
- CTSn raised at clock 40 of a 0x81 frame: the full 100-clock frame is sent intact, and iready stays 0 until CTSn returns low.
- resetn pulsed low at clock 55 of a frame: txd_pin=1 during and after reset, and no further start bit until a new handshake.
  - iready=0 for at least 2 clocks after release.
- STOP_BITS=2, send 0x00: txd_pin low for 90 clocks, then high for 20 clocks before iready rises; total frame 110 clocks.

Source files
------------

// File: rtl/axis_to_rs232.sv
// AXI-stream byte to RS232 transmitter with CTSn flow control.
// Frames are 8N1 or 8N2, sent LSB first, with one idle cycle between frames.
module axis_to_rs232 #(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  STOP_BITS  = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic       txd_pin,
    input  logic       ctsn_pin
);

    localparam int BAUD_COUNT_FULL = $rtoi(CLOCK_FREQ / BAUD_RATE + 0.5);
    localparam int CNT_W = $clog2(BAUD_COUNT_FULL + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BAUD_COUNT_FULL);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    if (BAUD_COUNT_FULL < 2) begin : g_bad_baud
        $error("axis_to_rs232: CLOCK_FREQ/BAUD_RATE must round to at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("axis_to_rs232: STOP_BITS must be 1 or 2");
    end

    logic [1:0]       cts_sync;
    logic             cts_ok;
    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic             baud_tick;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             take;

    assign cts_ok    = ~cts_sync[1];
    assign iready    = (state == ST_IDLE) && cts_ok;
    assign take      = ivalid && iready;
    assign baud_tick = (state != ST_IDLE) && (baud_cnt == CNT_ONE);

    // Sync flops reset to "blocked" so nothing is accepted until CTSn is seen low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], ctsn_pin};
        end
    end

    // txd_pin is loaded with the level of the state being entered, so each
    // bit appears on the pin for exactly one full baud period.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd_pin  <= 1'b1;
        end else if (state == ST_IDLE) begin
            if (take) begin
                state    <= ST_START;
                baud_cnt <= CNT_LOAD;
                txd_pin  <= 1'b0;
            end
        end else if (baud_tick) begin
            baud_cnt <= CNT_LOAD;
            case (state)
                ST_START: begin
                    state   <= ST_DATA;
                    bit_idx <= '0;
                    txd_pin <= shift[0];
                end
                ST_DATA: begin
                    if (bit_idx == 3'd7) begin
                        state   <= ST_STOP;
                        bit_idx <= '0;
                        txd_pin <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        txd_pin <= shift[1];
                    end
                end
                ST_STOP: begin
                    if (bit_idx == LAST_STOP) begin
                        state <= ST_IDLE;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                    end
                    txd_pin <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    txd_pin <= 1'b1;
                end
            endcase
        end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (take) begin
            shift <= idata;
        end else if (baud_tick && state == ST_DATA) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

endmodule

// File: tb/tb_axis_to_rs232.sv
// Self-checking bench for axis_to_rs232: an 8N1 instance and an 8N2 instance,
// both at N=10 clocks per bit, checked against an ideal frame waveform.
module tb_axis_to_rs232;

    localparam int N = 10;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ctsn = 1'b0;
    logic [7:0] idata_a = 8'h00;
    logic [7:0] idata_b = 8'h00;
    logic       ivalid_a = 1'b0;
    logic       ivalid_b = 1'b0;
    logic       iready_a, iready_b;
    logic       txd_a, txd_b;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int last_start = 0;

    axis_to_rs232 #(.CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .STOP_BITS(1)) dut_a (
        .clock(clock), .resetn(resetn), .idata(idata_a), .ivalid(ivalid_a),
        .iready(iready_a), .txd_pin(txd_a), .ctsn_pin(ctsn)
    );

    axis_to_rs232 #(.CLOCK_FREQ(1.0e6), .BAUD_RATE(1.0e5), .STOP_BITS(2)) dut_b (
        .clock(clock), .resetn(resetn), .idata(idata_b), .ivalid(ivalid_b),
        .iready(iready_b), .txd_pin(txd_b), .ctsn_pin(ctsn)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Hands one byte over, then compares every cycle of the frame with the ideal
    // waveform: start bit, data LSB first, stop bits, each level N clocks long.
    task automatic apply_stimulus(input bit sel, input logic [7:0] data, input int stops,
                                  input int cts_rise, input bit hold_valid,
                                  input logic [7:0] next_data, input int gap);
        int         frame_len;
        logic [7:0] decoded;
        logic       exp_bit;
        logic       t;
        frame_len = (9 + stops) * N;
        decoded = 8'h00;
        if (sel) begin idata_b = data; ivalid_b = 1'b1; end
        else begin idata_a = data; ivalid_a = 1'b1; end
        check_bit("ready_before_frame", sel ? iready_b : iready_a, 1'b1);
        step();
        if (gap > 0) check_output("start_gap", 32'(cycle - last_start), 32'(gap));
        last_start = cycle;
        for (int k = 0; k < frame_len; k++) begin
            if (k == frame_len - 1) begin
                if (sel) begin ivalid_b = hold_valid; idata_b = next_data; end
                else begin ivalid_a = hold_valid; idata_a = next_data; end
            end else begin
                if (sel) begin ivalid_b = 1'($urandom); idata_b = 8'($urandom); end
                else begin ivalid_a = 1'($urandom); idata_a = 8'($urandom); end
            end
            if (k == cts_rise) ctsn = 1'b1;
            if (k < N) exp_bit = 1'b0;
            else if (k < 9 * N) exp_bit = data[3'((k / N) - 1)];
            else exp_bit = 1'b1;
            t = sel ? txd_b : txd_a;
            check_bit("frame_txd", t, exp_bit);
            check_bit("frame_ready_low", sel ? iready_b : iready_a, 1'b0);
            if (k >= N && k < 9 * N && (k % N) == N / 2) decoded[3'((k / N) - 1)] = t;
            step();
        end
        check_output("decoded_byte", 32'(decoded), 32'(data));
        check_bit("frame_end_txd", sel ? txd_b : txd_a, 1'b1);
        check_bit("frame_end_ready", sel ? iready_b : iready_a, cts_rise < 0);
    endtask

    initial begin
        logic [7:0] cur, nxt;
        bit         hold, prev_hold;
        int         w;

        step();
        step();
        check_bit("reset_txd_a", txd_a, 1'b1);
        check_bit("reset_txd_b", txd_b, 1'b1);
        check_bit("reset_ready_a", iready_a, 1'b0);
        check_bit("reset_ready_b", iready_b, 1'b0);
        resetn = 1'b1;
        step();
        check_bit("ready_sync_1clk", iready_a, 1'b0);
        step();
        check_bit("ready_sync_2clk_a", iready_a, 1'b1);
        check_bit("ready_sync_2clk_b", iready_b, 1'b1);

        $display("[TB] single 0x55 frame");
        apply_stimulus(1'b0, 8'h55, 1, -1, 1'b0, 8'h00, 0);

        $display("[TB] back-to-back 0xA5, 0x3C");
        apply_stimulus(1'b0, 8'hA5, 1, -1, 1'b1, 8'h3C, 0);
        apply_stimulus(1'b0, 8'h3C, 1, -1, 1'b0, 8'h00, (9 + 1) * N + 1);

        $display("[TB] random byte stream");
        cur = 8'($urandom);
        prev_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nxt = 8'($urandom);
            hold = (i == 5) ? 1'b0 : 1'($urandom);
            apply_stimulus(1'b0, cur, 1, -1, hold, nxt, prev_hold ? (9 + 1) * N + 1 : 0);
            if (!hold) begin
                for (int j = 0; j < int'($urandom_range(0, 3)); j++) step();
            end
            cur = nxt;
            prev_hold = hold;
        end

        $display("[TB] CTSn held high");
        ctsn = 1'b1;
        step(); step(); step();
        ivalid_a = 1'b1;
        idata_a = 8'hFF;
        for (int k = 0; k < 200; k++) begin
            check_bit("cts_block_ready", iready_a, 1'b0);
            check_bit("cts_block_txd", txd_a, 1'b1);
            step();
        end
        ctsn = 1'b0;
        w = 0;
        while (!iready_a && w < 6) begin
            step();
            w++;
        end
        check_bit("cts_release_within_3", w <= 3, 1'b1);
        apply_stimulus(1'b0, 8'hFF, 1, -1, 1'b0, 8'h00, 0);

        $display("[TB] CTSn raised mid-frame");
        apply_stimulus(1'b0, 8'h81, 1, 40, 1'b0, 8'h00, 0);
        ivalid_a = 1'b1;
        idata_a = 8'h5A;
        for (int k = 0; k < 20; k++) begin
            check_bit("cts_mid_ready_low", iready_a, 1'b0);
            check_bit("cts_mid_txd_idle", txd_a, 1'b1);
            step();
        end
        ctsn = 1'b0;
        w = 0;
        while (!iready_a && w < 6) begin
            step();
            w++;
        end
        check_bit("cts_mid_release", w <= 3, 1'b1);
        apply_stimulus(1'b0, 8'h5A, 1, -1, 1'b0, 8'h00, 0);

        $display("[TB] reset during a frame");
        idata_a = 8'h00;
        ivalid_a = 1'b1;
        step();
        ivalid_a = 1'b0;
        for (int k = 0; k < 55; k++) step();
        check_bit("pre_reset_txd_low", txd_a, 1'b0);
        resetn = 1'b0;
        #1;
        check_bit("reset_async_txd", txd_a, 1'b1);
        check_bit("reset_async_ready", iready_a, 1'b0);
        step();
        step();
        check_bit("reset_hold_txd", txd_a, 1'b1);
        resetn = 1'b1;
        step();
        check_bit("post_reset_ready_1clk", iready_a, 1'b0);
        check_bit("post_reset_txd", txd_a, 1'b1);
        step();
        check_bit("post_reset_ready_2clk", iready_a, 1'b1);
        for (int k = 0; k < 30; k++) begin
            check_bit("post_reset_no_start", txd_a, 1'b1);
            step();
        end
        apply_stimulus(1'b0, 8'($urandom), 1, -1, 1'b0, 8'h00, 0);

        $display("[TB] two stop bits");
        apply_stimulus(1'b1, 8'h00, 2, -1, 1'b0, 8'h00, 0);
        apply_stimulus(1'b1, 8'($urandom), 2, -1, 1'b1, 8'hC3, 0);
        apply_stimulus(1'b1, 8'hC3, 2, -1, 1'b0, 8'h00, (9 + 2) * N + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
